// File: rtl/radio_en_sync_ctrl.sv
// rtl/radio_en_sync_ctrl.sv - multi-channel radio enable sequencer with PLL settle qualification
module radio_en_sync_ctrl #(
  parameter int NUM_CH        = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              ck,
  input  logic              arst,
  input  logic [NUM_CH-1:0] pll_settled,
  input  logic [NUM_CH-1:0] rx_req,
  output logic [NUM_CH-1:0] radio_enable_synced,
  output logic [NUM_CH-1:0] radio_rx_en_synced,
  output logic [NUM_CH-1:0] lock_lost,
  output logic              all_enabled
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_SETTLING = 2'd1,
    ST_ON       = 2'd2,
    ST_RX       = 2'd3
  } state_t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] pll_sync_q;
    logic [SYNC_STAGES-1:0] rx_sync_q;
    logic                   pll_s;
    logic                   rx_s;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   en_q;
    logic                   rx_en_q;
    logic                   lost_q;

    // Shift both asynchronous inputs through their own synchronizer chains
    always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
        pll_sync_q <= '0;
        rx_sync_q  <= '0;
      end else begin
        pll_sync_q <= {pll_sync_q[SYNC_STAGES-2:0], pll_settled[c]};
        rx_sync_q  <= {rx_sync_q[SYNC_STAGES-2:0], rx_req[c]};
      end
    end

    assign pll_s = pll_sync_q[SYNC_STAGES-1];
    assign rx_s  = rx_sync_q[SYNC_STAGES-1];

    // Channel sequencer: qualify lock, gate RX behind enable, flag lock loss
    always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        rx_en_q <= 1'b0;
        lost_q  <= 1'b0;
      end else begin
        lost_q <= 1'b0;
        case (state_q)
          ST_OFF: begin
            if (pll_s) begin
              state_q <= ST_SETTLING;
              cnt_q   <= CW'(1);
            end
          end
          ST_SETTLING: begin
            if (!pll_s) begin
              // Dropout while settling is silent; qualification restarts
              state_q <= ST_OFF;
              cnt_q   <= '0;
            end else if (cnt_q == SETTLE_MAX) begin
              state_q <= ST_ON;
              en_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_ON: begin
            if (!pll_s) begin
              state_q <= ST_OFF;
              cnt_q   <= '0;
              en_q    <= 1'b0;
              lost_q  <= 1'b1;
            end else if (rx_s) begin
              state_q <= ST_RX;
              rx_en_q <= 1'b1;
            end
          end
          ST_RX: begin
            if (!pll_s) begin
              state_q <= ST_OFF;
              cnt_q   <= '0;
              en_q    <= 1'b0;
              rx_en_q <= 1'b0;
              lost_q  <= 1'b1;
            end else if (!rx_s) begin
              state_q <= ST_ON;
              rx_en_q <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rx_en_q <= 1'b0;
          end
        endcase
      end
    end

    assign radio_enable_synced[c] = en_q;
    assign radio_rx_en_synced[c]  = rx_en_q;
    assign lock_lost[c]           = lost_q;
  end

  assign all_enabled = &radio_enable_synced;

endmodule

// File: tb/tb_radio_en_sync_ctrl.sv
// tb/tb_radio_en_sync_ctrl.sv - scoreboard bench for radio_en_sync_ctrl
module tb_radio_en_sync_ctrl;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } ev_t;

  logic       ck = 1'b0;
  logic       arst_a = 1'b1;
  logic       arst_b = 1'b1;
  logic [1:0] pll_a, rx_a, en_a, rxen_a, lost_a;
  logic       all_a;
  logic [3:0] pll_b, rx_b, en_b, rxen_b, lost_b;
  logic       all_b;

  int  cyc = 0;
  int  e0 = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  ev_t qa[$];
  ev_t qb[$];

  logic [15:0] outs_a, outs_b, prev_a, prev_b;
  logic        started_a = 1'b0;
  logic        started_b = 1'b0;
  ev_t         ev_a, ev_b;

  assign outs_a = {9'b0, all_a, lost_a, rxen_a, en_a};
  assign outs_b = {3'b0, all_b, lost_b, rxen_b, en_b};

  radio_en_sync_ctrl dut_a (
    .ck                  (ck),
    .arst                (arst_a),
    .pll_settled         (pll_a),
    .rx_req              (rx_a),
    .radio_enable_synced (en_a),
    .radio_rx_en_synced  (rxen_a),
    .lock_lost           (lost_a),
    .all_enabled         (all_a)
  );

  radio_en_sync_ctrl #(
    .NUM_CH        (4),
    .SYNC_STAGES   (3),
    .SETTLE_CYCLES (1)
  ) dut_b (
    .ck                  (ck),
    .arst                (arst_b),
    .pll_settled         (pll_b),
    .rx_req              (rx_b),
    .radio_enable_synced (en_b),
    .radio_rx_en_synced  (rxen_b),
    .lock_lost           (lost_b),
    .all_enabled         (all_b)
  );

  always #5 ck = ~ck;

  always @(posedge ck) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #2;
  endtask

  task automatic push_a(input int k, input logic [15:0] v);
    ev_t e;
    e.cyc = e0 + k;
    e.val = v;
    qa.push_back(e);
  endtask

  task automatic push_b(input int k, input logic [15:0] v);
    ev_t e;
    e.cyc = e0 + k;
    e.val = v;
    qb.push_back(e);
  endtask

  // Monitor A: every change of the output vector must match the next expected event
  always @(negedge ck) begin
    if (!started_a) begin
      started_a = 1'b1;
      n_chk++;
      if (outs_a !== 16'h0) begin
        n_fail++;
        $display("FAIL a_reset: got %h, expected 0000", outs_a);
      end
      prev_a = outs_a;
    end else if (outs_a !== prev_a) begin
      n_chk++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_spurious at cycle %0d: got %h, expected no change from %h", cyc, outs_a, prev_a);
      end else begin
        ev_a = qa.pop_front();
        if (ev_a.cyc != cyc || ev_a.val !== outs_a) begin
          n_fail++;
          $display("FAIL a_event: got %h at cycle %0d, expected %h at cycle %0d", outs_a, cyc, ev_a.val, ev_a.cyc);
        end
      end
      prev_a = outs_a;
    end
  end

  // Monitor B: same scheme for the 4-channel, 3-stage, 1-cycle-settle instance
  always @(negedge ck) begin
    if (!started_b) begin
      started_b = 1'b1;
      n_chk++;
      if (outs_b !== 16'h0) begin
        n_fail++;
        $display("FAIL b_reset: got %h, expected 0000", outs_b);
      end
      prev_b = outs_b;
    end else if (outs_b !== prev_b) begin
      n_chk++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_spurious at cycle %0d: got %h, expected no change from %h", cyc, outs_b, prev_b);
      end else begin
        ev_b = qb.pop_front();
        if (ev_b.cyc != cyc || ev_b.val !== outs_b) begin
          n_fail++;
          $display("FAIL b_event: got %h at cycle %0d, expected %h at cycle %0d", outs_b, cyc, ev_b.val, ev_b.cyc);
        end
      end
      prev_b = outs_b;
    end
  end

  // Directed stimulus; expected output vectors are {all, lock_lost, rx_en, en}
  initial begin
    pll_a = '0; rx_a = '0; pll_b = '0; rx_b = '0;
    step(3);
    arst_a = 1'b0;
    step(3);

    pll_a[0] = 1'b1; e0 = cyc; push_a(7, 16'h0001); step(10);

    pll_a[1] = 1'b1; step(3);
    pll_a[1] = 1'b0; step(8);

    pll_a[1] = 1'b1; e0 = cyc; push_a(7, 16'h0043); step(10);

    rx_a[0] = 1'b1; e0 = cyc; push_a(3, 16'h0047); step(6);
    rx_a[0] = 1'b0; e0 = cyc; push_a(3, 16'h0043); step(6);

    rx_a[0] = 1'b1; e0 = cyc; push_a(3, 16'h0047); step(6);
    pll_a[0] = 1'b0; e0 = cyc; push_a(3, 16'h0012); push_a(4, 16'h0002); step(12);

    pll_a[0] = 1'b1; e0 = cyc; push_a(7, 16'h0043); push_a(8, 16'h0047); step(12);

    pll_a = '0; rx_a = '0; e0 = cyc; push_a(3, 16'h0030); push_a(4, 16'h0000); step(8);

    arst_b = 1'b0; step(2);
    pll_b = 4'hF; rx_b = 4'hF; e0 = cyc; push_b(5, 16'h100F); push_b(6, 16'h10FF); step(10);
    arst_b = 1'b1; e0 = cyc; push_b(0, 16'h0000); step(3);
    arst_b = 1'b0; e0 = cyc; push_b(5, 16'h100F); push_b(6, 16'h10FF); step(10);

    n_chk++;
    if (qa.size() != 0) begin
      n_fail++;
      $display("FAIL a_pending: got %0d unobserved events, expected 0", qa.size());
    end
    n_chk++;
    if (qb.size() != 0) begin
      n_fail++;
      $display("FAIL b_pending: got %0d unobserved events, expected 0", qb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/radio_en_sync_ctrl.md
# radio_en_sync_ctrl

Multi-channel radio enable sequencer for the timing engine. Each channel brings the asynchronous PLL-settled and RX-request inputs into the `ck` domain through a configurable synchronizer chain. A per-channel state machine then qualifies PLL lock over a programmable settle window before asserting the radio enable, gates RX enable behind it, and reports loss of lock. The block sits between the analog/PLL status inputs and the radio front-end enable logic. It replaces the single-flop per-bit synchronizer used for the same signals.

## Interface
Parameters:
- NUM_CH, 2, number of independent radio channels (≥1)
- SYNC_STAGES, 2, synchronizer flops per asynchronous input (≥2)
- SETTLE_CYCLES, 4, consecutive synchronized-high cycles of pll_settled required before enable (≥1)

Ports:
- ck  in  1  clock
- arst  in  1  reset, asynchronous, active-high
- pll_settled  in  NUM_CH  per-channel PLL lock status, asynchronous to ck
- rx_req  in  NUM_CH  per-channel RX request, asynchronous to ck
- radio_enable_synced  out  NUM_CH  per-channel radio enable, registered
- radio_rx_en_synced  out  NUM_CH  per-channel RX enable, registered
- lock_lost  out  NUM_CH  one-cycle pulse when an enabled channel loses PLL lock, registered
- all_enabled  out  1  AND of all radio_enable_synced bits

## Operation
- Each channel has two SYNC_STAGES-deep synchronizer chains. Their final-stage outputs are pll_s and rx_s. Channels are fully independent.
- Per-channel FSM states and counter:
  - States: OFF, SETTLING, ON, RX.
  - The counter is wide enough to hold SETTLE_CYCLES.
- OFF:
  - If pll_s=1, go to SETTLING with cnt=1.
- SETTLING:
  - If pll_s=0, go to OFF.
  - Else if cnt==SETTLE_CYCLES, go to ON.
  - Else cnt+1.
- ON:
  - If pll_s=0, go to OFF and pulse lock_lost.
  - Else if rx_s=1, go to RX.
- RX:
  - If pll_s=0, go to OFF and pulse lock_lost.
  - Else if rx_s=0, go to ON.
- Output decodes:
  - radio_enable_synced = state ∈ {ON, RX}.
  - radio_rx_en_synced = state==RX.
  - All three outputs are flops updated on the state transition edge.
- Priority: loss of lock overrides everything. RX is never entered directly from SETTLING, even if rx_s=1; the channel passes through ON for one cycle.
- rx_req is ignored in OFF and SETTLING. If it is still high when ON is reached, RX follows on the next edge.
- A pll_s drop during SETTLING returns the channel to OFF silently (no lock_lost) and restarts qualification.
- all_enabled is combinational from registered enables.

## Timing
- Reset: while arst=1, and immediately on its assertion:
  - all synchronizer flops are 0;
  - all FSMs are in OFF with cnt=0;
  - radio_enable_synced, radio_rx_en_synced, lock_lost and all_enabled are all 0.
- Reset mid-operation drops every enable asynchronously with no lock_lost pulse. After release, each channel re-qualifies from OFF.
- Edge numbering: edge 1 is the first ck rising edge that samples the input at its new level (input stable thereafter).
- Enable latency: radio_enable_synced rises after edge SYNC_STAGES+SETTLE_CYCLES+1 (defaults: edge 7).
- RX latency from ON: radio_rx_en_synced rises after edge SYNC_STAGES+1 of the rx_req rise and falls after edge SYNC_STAGES+1 of its fall.
- Lock-loss latency: radio_enable_synced and radio_rx_en_synced fall after edge SYNC_STAGES+1 of the pll_settled fall. lock_lost is high for exactly that following cycle.
- Glitch rejection: a pll_s high run shorter than SETTLE_CYCLES never asserts enable.

## Test plan
- Defaults; release arst, then raise pll_settled[0] -> radio_enable_synced[0] high after edge 7, channel 1 stays 0, all_enabled stays 0.
- Pulse pll_settled[1] high for 3 cycles, then low -> radio_enable_synced[1] never asserts and lock_lost[1] stays 0. Re-raise and hold -> enable after edge 7 of the new rise.
- Both channels ON, then raise rx_req[0] -> radio_rx_en_synced[0] high after edge 3. Drop rx_req[0] -> low after edge 3. radio_enable_synced[0] stays 1 throughout.
- Channel 0 in RX, then drop pll_settled[0] -> enable and rx_en fall together after edge 3, and lock_lost[0] is a single one-cycle pulse. rx_req[0] still high causes no re-entry until re-qualification.
- Hold rx_req[0]=1 before raising pll_settled[0] -> enable rises after edge 7 and rx_en rises one cycle later (after edge 8).
- NUM_CH=4, SYNC_STAGES=3, SETTLE_CYCLES=1; assert arst mid-RX -> all outputs 0 immediately with no lock_lost. After release with inputs held high, enable rises after edge 5.
